// File: rtl/sound_card_pkg.sv
// sound_card_pkg: shared definitions for the sound card core.
//   - command codes and note-word field positions
//   - decoded note structure and decode helper
//   - voice index and playback state enumerations
package sound_card_pkg;

  localparam logic [7:0] CMD_PLAY = 8'h00;
  localparam logic [7:0] CMD_END  = 8'h11;

  // Note word layout: [31:24] cmd, [23:20] voice mask, [19:8] period, [7:0] duration
  localparam int CMD_MSB  = 31;
  localparam int CMD_LSB  = 24;
  localparam int MASK_MSB = 23;
  localparam int MASK_LSB = 20;
  localparam int PER_MSB  = 19;
  localparam int PER_LSB  = 8;
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 0;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [3:0]  mask;
    logic [11:0] period;
    logic [7:0]  dur;
  } note_t;

  typedef enum logic [1:0] {
    V_SQUARE   = 2'd0,
    V_TRIANGLE = 2'd1,
    V_SAW      = 2'd2,
    V_NOISE    = 2'd3
  } voice_e;

  typedef enum logic {
    PLAY = 1'b0,
    DONE = 1'b1
  } state_e;

  function automatic note_t decode_note(input logic [31:0] w);
    note_t n;
    n.cmd    = w[CMD_MSB:CMD_LSB];
    n.mask   = w[MASK_MSB:MASK_LSB];
    n.period = w[PER_MSB:PER_LSB];
    n.dur    = w[DUR_MSB:DUR_LSB];
    return n;
  endfunction

endpackage

// File: rtl/music_storage.sv
// music_storage: preloaded note store with a combinational read.
//   addr : word address
//   note : mem[addr]
// The array has no write port; contents are placed by backdoor load.
module music_storage #(
  parameter  int MEM_DEPTH = 256,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   note
);

  // NOTE: the note store is not reset; its contents must survive rst_n so a
  // song loaded once can be replayed, and clearing it would cost a per-word write path.
  logic [31:0] mem [0:MEM_DEPTH-1];

  assign note = mem[addr];

endmodule

// File: rtl/sound_card_ctrl.sv
// sound_card_ctrl: sequencing for the note list.
//   clk, rst_n : clock, async active-low reset
//   active     : a play/rest note is sounding (not at END, not halted)
//   play_en    : active and the note is a play command (voices audible)
//   note_last  : final clock of the current note
//   mask       : voice enable mask of the current note
//   period     : tone step period P of the current note
// Holds the note address, duration counters and PLAY/DONE state, plus the store.
module sound_card_ctrl
  import sound_card_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int DUR_UNIT  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        active,
  output logic        play_en,
  output logic        note_last,
  output logic [3:0]  mask,
  output logic [11:0] period
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int UW = (DUR_UNIT > 1) ? $clog2(DUR_UNIT) : 1;

  logic [AW-1:0] addr;
  logic [31:0]   note;
  note_t         nt;
  state_e        state, state_next;
  logic [UW-1:0] unit_cnt;
  logic [7:0]    tick_cnt;
  logic          is_end;
  logic          unit_last;

  music_storage #(.MEM_DEPTH(MEM_DEPTH)) music_storage (
    .addr (addr),
    .note (note)
  );

  assign nt        = decode_note(note);
  // An X/Z command compares unknown and is therefore not taken as END.
  assign is_end    = (nt.cmd == CMD_END);
  assign active    = (state == PLAY) && !is_end;
  assign play_en   = active && (nt.cmd == CMD_PLAY);
  assign unit_last = (unit_cnt == UW'(DUR_UNIT - 1));
  assign note_last = active && unit_last && (tick_cnt == nt.dur);
  assign mask      = nt.mask;
  assign period    = nt.period;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (state == PLAY && is_end) state_next = DONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PLAY;
    else        state <= state_next;
  end

  // A note lasts (D+1)*DUR_UNIT clocks: unit_cnt counts clocks within a tick,
  // tick_cnt counts ticks. Address and counters freeze once END is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      unit_cnt <= '0;
      tick_cnt <= '0;
    end else if (active) begin
      if (note_last) begin
        unit_cnt <= '0;
        tick_cnt <= '0;
        addr     <= (addr == AW'(MEM_DEPTH - 1)) ? '0 : addr + 1'b1;
      end else if (unit_last) begin
        unit_cnt <= '0;
        tick_cnt <= tick_cnt + 8'd1;
      end else begin
        unit_cnt <= unit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_card_core.sv
// sound_card_core: four-voice note-list synthesiser.
//   clk      : system clock, one sample per rising edge
//   rst_n    : asynchronous active-low reset
//   combined : registered signed 8-bit sum of the enabled voices
// Sequencing lives in in_ctrls; tone counters, voices and mixer live here.
module sound_card_core
  import sound_card_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int DUR_UNIT  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic signed [7:0] combined
);

  logic        active, play_en, note_last;
  logic [3:0]  mask;
  logic [11:0] period;
  logic [11:0] step_cnt;
  logic [5:0]  phase;
  logic [7:0]  lfsr;
  logic        phase_step;
  logic        lfsr_fb;
  logic [7:0]  voice [4];
  logic [7:0]  mix;

  sound_card_ctrl #(.MEM_DEPTH(MEM_DEPTH), .DUR_UNIT(DUR_UNIT)) in_ctrls (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (active),
    .play_en   (play_en),
    .note_last (note_last),
    .mask      (mask),
    .period    (period)
  );

  assign phase_step = active && (step_cnt == period);
  // Fibonacci taps 8,6,5,4 (1-based), shifted in at the LSB.
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Step counter runs 0..P; phase advances on each wrap, giving a
  // 64*(P+1)-clock waveform. Each new note restarts at phase 0. The LFSR is
  // not cleared between notes, only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      phase    <= '0;
      lfsr     <= LFSR_SEED;
    end else if (active) begin
      if (phase_step) lfsr <= {lfsr[6:0], lfsr_fb};
      if (note_last) begin
        step_cnt <= '0;
        phase    <= '0;
      end else if (phase_step) begin
        step_cnt <= '0;
        phase    <= phase + 6'd1;
      end else begin
        step_cnt <= step_cnt + 12'd1;
      end
    end
  end

  // Voices as 8-bit two's complement, each within -32..31.
  always_comb begin
    voice[V_SQUARE]   = phase[5] ? 8'hE0 : 8'd31;
    voice[V_SAW]      = {2'b00, phase} - 8'd32;
    voice[V_TRIANGLE] = phase[5] ? (8'd95 - {1'b0, phase, 1'b0})
                                 : ({1'b0, phase, 1'b0} - 8'd32);
    voice[V_NOISE]    = {2'b00, lfsr[5:0]} - 8'd32;
  end

  // Four voices in -32..31 sum to -128..124, so 8 bits never overflow.
  always_comb begin
    mix = '0;
    for (int v = 0; v < 4; v++) begin
      if (mask[v]) mix = mix + voice[v];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) combined <= '0;
    else        combined <= play_en ? $signed(mix) : 8'sd0;
  end

endmodule

// File: tb/tb_sound_card_core.sv
// tb_sound_card_core: self-checking bench for sound_card_core.
// Notes are backdoor-loaded into the store; expected samples come from a
// per-note model driven by elapsed time within each note.
module tb_sound_card_core;

  localparam int MEM_DEPTH = 256;
  localparam int DUR_UNIT  = 256;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] combined;

  int errors = 0;
  int checks = 0;

  logic [31:0] img [MEM_DEPTH];
  int          exp_q[$];
  int          obs_q[$];

  always #5 clk = ~clk;

  sound_card_core #(.MEM_DEPTH(MEM_DEPTH), .DUR_UNIT(DUR_UNIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .combined (combined)
  );

  // ---------------- reference model ----------------
  function automatic int lfsr_next(input int lf);
    int fb;
    fb = ((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1;
    return ((lf << 1) | fb) & 255;
  endfunction

  function automatic int voice_val(input int idx, input int ph, input int lf);
    case (idx)
      0: return (ph >= 32) ? -32 : 31;
      1: return (ph < 32) ? (2 * ph - 32) : (95 - 2 * ph);
      2: return ph - 32;
      default: return (lf % 64) - 32;
    endcase
  endfunction

  // Expected sample k (k=0 is the first edge after reset release).
  task automatic build_model(input int n);
    int lf, a, cmd, msk, p, d, len, ph, sum;
    exp_q.delete();
    lf = 255;
    a  = 0;
    while (exp_q.size() < n) begin
      cmd = int'(img[a][31:24]);
      msk = int'(img[a][23:20]);
      p   = int'(img[a][19:8]);
      d   = int'(img[a][7:0]);
      if (cmd == 'h11) begin
        while (exp_q.size() < n) exp_q.push_back(0);
      end else begin
        len = (d + 1) * DUR_UNIT;
        for (int t = 0; t < len && exp_q.size() < n; t++) begin
          ph  = (t / (p + 1)) % 64;
          sum = 0;
          if (cmd == 0)
            for (int v = 0; v < 4; v++)
              if ((msk >> v) & 1) sum += voice_val(v, ph, lf);
          exp_q.push_back(sum);
          if ((t + 1) % (p + 1) == 0) lf = lfsr_next(lf);
        end
        a = (a + 1) % MEM_DEPTH;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic clear_img();
    for (int i = 0; i < MEM_DEPTH; i++) img[i] = 32'h0;
  endtask

  task automatic start();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < MEM_DEPTH; i++) dut.in_ctrls.music_storage.mem[i] = img[i];
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
  endtask

  task automatic check_span(input string name, input int from, input int to);
    int shown;
    logic signed [7:0] e;
    shown = 0;
    for (int k = from; k < to; k++) begin
      @(posedge clk);
      #1;
      obs_q.push_back(int'(combined));
      e = 8'(exp_q[k]);
      checks++;
      if (combined !== e) begin
        errors++;
        if (shown < 5)
          $display("FAIL %s sample %0d: got %0d expected %0d", name, k + 1, combined, e);
        shown++;
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_img();
    img[0] = 32'h1100_0000;
    rst_n = 1'b0;
    #12;
    checks++;
    if (combined !== 8'sd0) begin
      errors++;
      $display("FAIL reset_combined: got %0d expected 0", combined);
    end
    start();
    #1;
    checks++;
    if (dut.in_ctrls.music_storage.note !== 32'h1100_0000) begin
      errors++;
      $display("FAIL reset_note: got %h expected 11000000", dut.in_ctrls.music_storage.note);
    end
    build_model(40);
    check_span("end_at_zero", 0, 40);
  endtask

  task automatic test_square();
    clear_img();
    img[0] = 32'h0010_0000;
    img[1] = 32'h1100_0000;
    start();
    build_model(300);
    check_span("square", 0, 300);
    check_val("square_s1", obs_q[0], 31);
    check_val("square_s32", obs_q[31], 31);
    check_val("square_s33", obs_q[32], -32);
    check_val("square_s65", obs_q[64], 31);
    check_val("square_s257_end", obs_q[256], 0);
  endtask

  task automatic test_saw();
    clear_img();
    img[0] = 32'h0040_0003;
    start();
    build_model(1100);
    check_span("saw", 0, 1024);
    check_val("saw_addr_after", int'(dut.in_ctrls.addr), 1);
    check_span("saw_next", 1024, 1100);
    check_val("saw_s1", obs_q[0], -32);
    check_val("saw_s64", obs_q[63], 31);
    check_val("saw_s1024", obs_q[1023], 31);
  endtask

  task automatic test_square_triangle();
    clear_img();
    img[0] = 32'h0030_0000;
    img[1] = 32'h1100_0000;
    start();
    build_model(300);
    check_span("sq_tri", 0, 300);
    check_val("sq_tri_s1", obs_q[0], -1);
    check_val("sq_tri_ph32", obs_q[32], -1);
  endtask

  task automatic test_rest();
    clear_img();
    img[0] = 32'h05F0_0000;
    img[1] = 32'h0010_0000;
    img[2] = 32'h1100_0000;
    start();
    build_model(600);
    check_span("rest", 0, 600);
    check_val("rest_s256", obs_q[255], 0);
    check_val("rest_next_s1", obs_q[256], 31);
  endtask

  task automatic test_random();
    int total;
    int c;
    clear_img();
    total = 0;
    for (int i = 0; i < 7; i++) begin
      c = 0;
      if ($urandom_range(0, 4) == 0) begin
        c = int'($urandom_range(1, 255));
        if (c == 'h11) c = 'h22;
      end
      img[i] = {8'(c), 4'($urandom_range(0, 15)), 12'($urandom_range(0, 5)),
                8'($urandom_range(0, 2))};
      total += (int'(img[i][7:0]) + 1) * DUR_UNIT;
    end
    img[0][31:20] = 12'h00F;   // first note always plays every voice, noise included
    img[7] = 32'h1100_0000;
    start();
    build_model(total + 64);
    check_span("random", 0, total + 64);
  endtask

  task automatic test_mid_reset();
    clear_img();
    img[0] = 32'h00F0_0201;
    img[1] = 32'h0050_0000;
    img[2] = 32'h1100_0000;
    start();
    build_model(900);
    check_span("pre_reset", 0, 137);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_combined", int'(combined), 0);
    check_val("async_reset_addr", int'(dut.in_ctrls.addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_span("post_reset", 0, 900);
  endtask

  initial begin
    test_reset();
    test_square();
    test_saw();
    test_square_triangle();
    test_rest();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
